// File: rtl/pwm_multichannel_peripheral.sv
// Multichannel PWM generator with a shared prescaler and a shared period counter.
// Duty, prescale and mode are double-buffered and reload only at period boundaries.
module pwm_multichannel_peripheral #(
    parameter int NUM_CH  = 16,
    parameter int DUTY_W  = 8,
    parameter int PRESC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        en_out,
    input  logic [NUM_CH-1:0]        en_pwm,
    input  logic [NUM_CH*DUTY_W-1:0] duty_in,
    input  logic [PRESC_W-1:0]       prescale_in,
    input  logic                     center_in,
    output logic [NUM_CH-1:0]        out,
    output logic                     period_start,
    output logic [DUTY_W-1:0]        cnt_dbg
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [DUTY_W-1:0] MAX = '1;

    logic [PRESC_W-1:0]       pc;
    logic [PRESC_W-1:0]       presc_act;
    logic [DUTY_W-1:0]        cnt;
    logic [NUM_CH*DUTY_W-1:0] duty_act;
    logic                     center_act;
    dir_t                     dir;
    logic                     tick;
    logic                     boundary;
    logic [NUM_CH-1:0]        pwm;

    assign tick     = (pc == presc_act);
    assign boundary = tick && (cnt == '0);
    assign cnt_dbg  = cnt;

    function automatic logic compare(input logic [DUTY_W-1:0] d, input logic [DUTY_W-1:0] c);
        return (d == MAX) || (c < d);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    // The boundary tick always leaves cnt at 1 going up, so a mode switch restarts cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            dir        <= DIR_UP;
            duty_act   <= '0;
            presc_act  <= '0;
            center_act <= 1'b0;
        end else if (boundary) begin
            cnt        <= DUTY_W'(1);
            dir        <= DIR_UP;
            duty_act   <= duty_in;
            presc_act  <= prescale_in;
            center_act <= center_in;
        end else if (tick) begin
            if (!center_act) begin
                cnt <= cnt + 1'b1;
            end else if (dir == DIR_UP) begin
                if (cnt == MAX) begin
                    cnt <= MAX - 1'b1;
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // On the boundary tick the freshly loaded duty is bypassed so cnt==0 sees the new value.
    always_comb begin
        pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm[i] = compare(boundary ? duty_in[i*DUTY_W +: DUTY_W]
                                      : duty_act[i*DUTY_W +: DUTY_W], cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            out          <= en_out & (~en_pwm | pwm);
            period_start <= boundary;
        end
    end

endmodule

// File: doc/pwm_multichannel_peripheral.md
Name: pwm_multichannel_peripheral

Overview:
Parametrised successor to the single-shared-duty 16-channel PWM peripheral. It drives NUM_CH outputs with an independent duty cycle per channel. Timing comes from a shared programmable prescaler and a common period counter, which runs either edge-aligned or center-aligned. Duty, prescale and mode are double-buffered and take effect only at a period boundary, so outputs never glitch. The block sits between the SPI register file and the {uio_out, uo_out} pins in the top level.

Parameters:
NUM_CH, 16, number of output channels (1..32)
DUTY_W, 8, duty/counter width; MAX = 2^DUTY_W - 1
PRESC_W, 8, prescaler reload width

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_out  input  NUM_CH  per-channel output enable; 0 forces the channel low
en_pwm  input  NUM_CH  per-channel PWM enable; 0 with en_out=1 gives a static high
duty_in  input  NUM_CH*DUTY_W  flat duty bus; channel i uses bits [i*DUTY_W +: DUTY_W]
prescale_in  input  PRESC_W  tick every prescale_in+1 clocks
center_in  input  1  0 = edge-aligned, 1 = center-aligned
out  output  NUM_CH  registered PWM outputs
period_start  output  1  one-clock pulse at each period boundary
cnt_dbg  output  DUTY_W  current period counter value

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all counters 0, duty_act 0, presc_act 0, center_act 0, dir=up, out 0, period_start 0, cnt_dbg 0. Assertion mid-operation clears all state immediately, without waiting for a clock edge.
- Prescaler counter pc: reset to 0.
  - tick = (pc == presc_act).
  - On tick pc <= 0; otherwise pc <= pc+1.
  - prescale_in=0 gives a tick on every clock.
- Period counter cnt advances only on tick.
  - Edge mode: 0,1,...,MAX, then wraps to 0. Period = 2^DUTY_W ticks.
  - Center mode: counts up 0..MAX, then down MAX-1..1, then back to 0. Direction flips at MAX and at 0. Period = 2*MAX ticks.
- Boundary: a tick while cnt==0, including the first tick after reset.
  - On the boundary, duty_act[i] <= duty_in[i], presc_act <= prescale_in and center_act <= center_in, all in the same edge.
  - period_start is registered high for exactly that one clock.
  - Changes to the inputs between boundaries have no effect on the outputs.
  - A mode change takes effect at the boundary; cnt restarts at 0 with dir=up.
- Compare, evaluated per clock for each channel i, with d = the duty value in effect for the current cnt:
  - At cnt==0 on the boundary tick, d is the newly loaded value (bypass).
  - Otherwise d = duty_act[i].
  - pwm_i = 1 if d==MAX; else (cnt < d).
  - d==0 gives a constant low.
- Output gating, registered (one clock latency from cnt):
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_i : 1) : 0.
  - en_out and en_pwm are not buffered and take effect on the next clock.
- High time:
  - Edge mode: d ticks per period.
  - Center mode: 2d-1 ticks for 1<=d<MAX, pulse centered on cnt==0.
  - d==MAX is 100% high in both modes.
- cnt_dbg = cnt, driven combinationally from the register.
- Simultaneous events: a boundary and a prescale_in change in the same clock load the new prescale value, which governs the next tick interval. No other simultaneous-event ordering is needed, since all updates share the boundary.

Test Plan:
- Reset, then en_out=all 1, en_pwm=all 1, duty ch0=64, prescale 0, edge mode -> period_start every 256 clocks; out[0] high exactly 64 consecutive clocks per period, low 192.
- Per-channel: ch1=0, ch2=128, ch3=255 -> out[1] never high; out[2] high 128/256; out[3] constantly high with no low glitch across the wrap.
- Prescale 3, ch0=10 -> period 1024 clocks; out[0] high 40 clocks per period.
- Center mode, prescale 0, ch0=64 -> period_start every 510 clocks; out[0] high 127 clocks centered on cnt==0.
- Change ch0 duty from 64 to 200 at cnt=100 -> current period is still 64 high; next period is 200 high; no runt pulse.
- en_out[5]=0 -> out[5]=0. en_pwm[6]=0 with en_out[6]=1 -> out[6]=1. Assert rst_n low mid-period -> all outputs 0 immediately (asynchronously); after release, first period_start occurs at the first tick.
